// File: rtl/param_cpu_pkg.sv
// Shared definitions for the param_cpu trainer core: opcodes, FSM states,
// the 16-bit instruction layout and a small decode helper.
package param_cpu_pkg;

  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BZ   = 4'h9;
  localparam logic [3:0] OP_OUT  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  // [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm
  typedef struct packed {
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
  } instr_t;

  // Ops 0..6 write a register and refresh the zero flag.
  function automatic logic op_writes_reg(input logic [3:0] op);
    return op <= OP_LD;
  endfunction

endpackage

// File: rtl/param_cpu_if.sv
// Board-side bus of the param_cpu core.
//   run        : level, 1 = execute, 0 = stop at next instruction boundary
//   prog_we/addr/data : program-memory load port (honoured in IDLE/HALT only)
//   cpu_out    : output register, written by OUT
//   out_valid  : 1-cycle pulse when cpu_out is updated
//   halted     : 1 while in HALT
//   busy       : 1 while FETCH..WB
// master = board/controller side, slave = CPU side.
interface param_cpu_if #(
  parameter int DW   = 8,
  parameter int PC_W = 6
);
  logic            run;
  logic            prog_we;
  logic [PC_W-1:0] prog_addr;
  logic [15:0]     prog_data;
  logic [DW-1:0]   cpu_out;
  logic            out_valid;
  logic            halted;
  logic            busy;

  modport master (
    output run, prog_we, prog_addr, prog_data,
    input  cpu_out, out_valid, halted, busy
  );

  modport slave (
    input  run, prog_we, prog_addr, prog_data,
    output cpu_out, out_valid, halted, busy
  );
endinterface

// File: rtl/param_alu.sv
// Combinational ALU of param_cpu.
//   op   : instruction opcode (ADD/SUB/AND/OR/XOR; LDI passes b through)
//   a, b : operands, DW bits
//   y    : result mod 2**DW (carry/borrow discarded)
//   zero : y == 0
module param_alu
  import param_cpu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y,
  output logic          zero
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_LDI:  y = b;
      default: y = '0;
    endcase
    zero = (y == '0);
  end

endmodule

// File: rtl/param_cpu.sv
// param_cpu: multi-cycle trainer CPU (FETCH -> DECODE -> EXEC -> WB, 4 cycles
// per instruction) with 4 x DW registers, 2**PC_W x 16 program memory and
// 2**DA_W x DW data memory, both synchronous-read.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : param_cpu_if slave (run, program load port, cpu_out,
//                out_valid, halted, busy)
module param_cpu
  import param_cpu_pkg::*;
#(
  parameter int DW   = 8,
  parameter int PC_W = 6,
  parameter int DA_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  param_cpu_if.slave   bus
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  instr_t          instr_q, instr_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [DW-1:0]   cpu_out_q, cpu_out_d;
  logic            z_q, z_d, alu_z_q, alu_z_d, out_valid_q, out_valid_d;
  logic [DW-1:0]   regs_q [4];
  logic [DW-1:0]   regs_d [4];

  logic [INSTR_W-1:0] imem [2**PC_W];
  logic [DW-1:0]      dmem [2**DA_W];
  instr_t             fetch_q;
  logic [DW-1:0]      ld_data_q;

  logic [DW-1:0]   alu_y;
  logic            alu_zero;
  logic            imem_we, dmem_we;
  logic [DA_W-1:0] daddr;
  logic [DW-1:0]   wb_data;

  assign daddr   = instr_q.imm[DA_W-1:0];
  // Loading is only safe while no instruction is in flight.
  assign imem_we = bus.prog_we && (state_q == S_IDLE || state_q == S_HALT);
  assign dmem_we = (state_q == S_EXEC) && (instr_q.op == OP_ST);
  assign wb_data = (instr_q.op == OP_LD) ? ld_data_q : res_q;

  param_alu #(.DW(DW)) u_alu (
    .op   (instr_q.op),
    .a    (a_q),
    .b    (b_q),
    .y    (alu_y),
    .zero (alu_zero)
  );

  // NOTE: memories carry no reset; program and data contents survive rst_n, and a resettable array would not map onto RAM.
  always_ff @(posedge clk) begin
    if (imem_we)             imem[bus.prog_addr] <= bus.prog_data;
    if (state_q == S_FETCH)  fetch_q             <= instr_t'(imem[pc_q]);
    if (dmem_we)             dmem[daddr]         <= a_q;
    if (state_q == S_EXEC)   ld_data_q           <= dmem[daddr];
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    alu_z_d     = alu_z_q;
    z_d         = z_q;
    cpu_out_d   = cpu_out_q;
    out_valid_d = 1'b0;
    regs_d      = regs_q;

    case (state_q)
      S_IDLE:   if (bus.run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        instr_d = fetch_q;
        a_d     = regs_q[fetch_q.rd];
        b_d     = (fetch_q.op == OP_LDI) ? fetch_q.imm[DW-1:0] : regs_q[fetch_q.rs];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_y;
        alu_z_d = alu_zero;
        // Registered here so cpu_out and out_valid appear together in WB.
        if (instr_q.op == OP_OUT) begin
          cpu_out_d   = a_q;
          out_valid_d = 1'b1;
        end
        state_d = S_WB;
      end
      S_WB: begin
        if (op_writes_reg(instr_q.op)) begin
          regs_d[instr_q.rd] = wb_data;
          z_d = (instr_q.op == OP_LD) ? (ld_data_q == '0) : alu_z_q;
        end
        pc_d = pc_q + 1'b1;
        if (instr_q.op == OP_JMP || (instr_q.op == OP_BZ && z_q))
          pc_d = instr_q.imm[PC_W-1:0];
        if (instr_q.op == OP_HALT) begin
          pc_d    = pc_q;
          state_d = S_HALT;
        end else begin
          state_d = bus.run ? S_FETCH : S_IDLE;
        end
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      instr_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      alu_z_q     <= 1'b0;
      z_q         <= 1'b0;
      cpu_out_q   <= '0;
      out_valid_q <= 1'b0;
      regs_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      alu_z_q     <= alu_z_d;
      z_q         <= z_d;
      cpu_out_q   <= cpu_out_d;
      out_valid_q <= out_valid_d;
      regs_q      <= regs_d;
    end
  end

  assign bus.cpu_out   = cpu_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.halted    = (state_q == S_HALT);
  assign bus.busy      = state_q inside {S_FETCH, S_DECODE, S_EXEC, S_WB};

endmodule

// File: tb/tb_param_cpu.sv
// Self-checking bench for param_cpu: directed program table, hand-written
// multi-cycle sequences, and random programs checked against an ISA-level
// interpreter. Two instances: A (DW=8, PC_W=6, DA_W=4), B (DW=4, PC_W=3, DA_W=2).
module tb_param_cpu;

  localparam int ADD = 0, SUB = 1, AND = 2, OR = 3, XOR = 4, LDI = 5, LD = 6;
  localparam int ST = 7, JMP = 8, BZ = 9, OUT = 10, HLT = 15;
  localparam logic [15:0] H = 16'hF000;

  typedef struct {
    logic [0:9][15:0] prog;
    int exp_out;
    int exp_cyc;
    int exp_halt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_na = 1'b0;
  logic rst_nb = 1'b0;

  param_cpu_if #(.DW(8), .PC_W(6)) ifa ();
  param_cpu_if #(.DW(4), .PC_W(3)) ifb ();

  param_cpu #(.DW(8), .PC_W(6), .DA_W(4)) dut_a (.clk(clk), .rst_n(rst_na), .bus(ifa));
  param_cpu #(.DW(4), .PC_W(3), .DA_W(2)) dut_b (.clk(clk), .rst_n(rst_nb), .bus(ifb));

  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] prog_buf [64];
  logic [31:0] got_val [$];
  int          got_cyc [$];
  int          exp_val [$];
  int          exp_cyc [$];
  int          halt_cyc;
  int          mdmem [16];
  vec_t        vecs [9];

  function automatic logic [15:0] e(input int op, input int rd, input int rs, input int imm);
    return 16'(((op & 15) << 12) | ((rd & 3) << 10) | ((rs & 3) << 8) | (imm & 255));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_buf();
    for (int i = 0; i < 64; i++) prog_buf[i] = H;
  endtask

  task automatic start_capture();
    got_val.delete();
    got_cyc.delete();
    halt_cyc = -1;
  endtask

  // ---------------- instance A helpers ----------------
  task automatic tick_a(input int cyc);
    @(negedge clk);
    if (ifa.out_valid === 1'b1) begin
      got_val.push_back(32'(ifa.cpu_out));
      got_cyc.push_back(cyc);
    end
    if (ifa.halted === 1'b1 && halt_cyc < 0) halt_cyc = cyc;
  endtask

  task automatic reset_a();
    @(negedge clk);
    ifa.run = 1'b0; ifa.prog_we = 1'b0; rst_na = 1'b0;
    @(negedge clk);
    rst_na = 1'b1;
  endtask

  task automatic load_a();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      ifa.prog_we = 1'b1; ifa.prog_addr = 6'(i); ifa.prog_data = prog_buf[i];
    end
    @(negedge clk);
    ifa.prog_we = 1'b0;
  endtask

  task automatic run_a(input int max_cyc, input bit stop_on_halt);
    start_capture();
    @(negedge clk);
    ifa.run = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      tick_a(c);
      if (stop_on_halt && halt_cyc >= 0) break;
    end
    ifa.run = 1'b0;
  endtask

  // ---------------- instance B helpers ----------------
  task automatic tick_b(input int cyc);
    @(negedge clk);
    if (ifb.out_valid === 1'b1) begin
      got_val.push_back(32'(ifb.cpu_out));
      got_cyc.push_back(cyc);
    end
    if (ifb.halted === 1'b1 && halt_cyc < 0) halt_cyc = cyc;
  endtask

  task automatic reset_b();
    @(negedge clk);
    ifb.run = 1'b0; ifb.prog_we = 1'b0; rst_nb = 1'b0;
    @(negedge clk);
    rst_nb = 1'b1;
  endtask

  task automatic run_b(input int max_cyc);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ifb.prog_we = 1'b1; ifb.prog_addr = 3'(i); ifb.prog_data = prog_buf[i];
    end
    @(negedge clk);
    ifb.prog_we = 1'b0;
    start_capture();
    @(negedge clk);
    ifb.run = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      tick_b(c);
      if (halt_cyc >= 0) break;
    end
    ifb.run = 1'b0;
  endtask

  // Compare captured OUT events (value, cycle) against index i of expectations.
  task automatic check_out(input string name, input int i, input int val, input int cyc);
    if (got_val.size() > i) begin
      check({name, "_val"}, got_val[i], val);
      check({name, "_cyc"}, got_cyc[i], cyc);
    end else begin
      check({name, "_present"}, 0, 1);
    end
  endtask

  // ISA-level reference for instance A: executes n instructions from prog_buf,
  // each taking 4 cycles, and records every OUT as (value, cycle of its WB).
  task automatic model_a(input int n);
    int r [4];
    int z, pc, w, op, rd, rs, imm, nxt, res;
    r = '{default: 0};
    z = 0; pc = 0;
    exp_val.delete(); exp_cyc.delete();
    for (int k = 0; k < n; k++) begin
      w = int'(prog_buf[pc]);
      op = w >> 12; rd = (w >> 10) & 3; rs = (w >> 8) & 3; imm = w & 255;
      nxt = (pc + 1) % 64;
      res = -1;
      case (op)
        ADD: res = (r[rd] + r[rs]) % 256;
        SUB: res = (r[rd] - r[rs] + 256) % 256;
        AND: res = r[rd] & r[rs];
        OR:  res = r[rd] | r[rs];
        XOR: res = r[rd] ^ r[rs];
        LDI: res = imm;
        LD:  res = mdmem[imm % 16];
        ST:  mdmem[imm % 16] = r[rd];
        JMP: nxt = imm % 64;
        BZ:  if (z != 0) nxt = imm % 64;
        OUT: begin exp_val.push_back(r[rd]); exp_cyc.push_back(4 * (k + 1)); end
        default: ;
      endcase
      if (res >= 0) begin
        r[rd] = res;
        z = (res == 0) ? 1 : 0;
      end
      pc = nxt;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.run = 1'b0; ifa.prog_we = 1'b0; ifa.prog_addr = '0; ifa.prog_data = '0;
    ifb.run = 1'b0; ifb.prog_we = 1'b0; ifb.prog_addr = '0; ifb.prog_data = '0;

    // {program (10 words), expected OUT value, its cycle, first halted cycle}
    vecs[0] = '{{e(LDI,0,0,5), e(LDI,1,0,3), e(ADD,0,1,0), e(OUT,0,0,0), H, H, H, H, H, H}, 8, 16, 21};
    vecs[1] = '{{e(LDI,0,0,2), e(LDI,1,0,2), e(SUB,0,1,0), e(BZ,0,0,6), e(OUT,0,0,0), H,
                 e(LDI,2,0,8'h66), e(OUT,2,0,0), H, H}, 8'h66, 24, 29};
    vecs[2] = '{{e(LDI,0,0,2), e(LDI,1,0,1), e(SUB,0,1,0), e(BZ,0,0,6), e(OUT,0,0,0), H,
                 e(LDI,2,0,8'h66), e(OUT,2,0,0), H, H}, 1, 20, 25};
    vecs[3] = '{{e(LDI,2,0,8'hA5), e(ST,2,0,3), e(LDI,2,0,0), e(LD,3,0,3), e(OUT,3,0,0), H, H, H, H, H},
                8'hA5, 20, 25};
    vecs[4] = '{{e(LDI,0,0,8'hCC), e(LDI,1,0,8'hAA), e(XOR,0,1,0), e(OR,0,1,0), e(OUT,0,0,0), H, H, H, H, H},
                8'hEE, 20, 25};
    vecs[5] = '{{e(LDI,0,0,8'hF0), e(LDI,3,0,8'h3C), e(AND,3,0,0), e(OUT,3,0,0), H, H, H, H, H, H},
                8'h30, 16, 21};
    vecs[6] = '{{e(LDI,1,0,1), e(SUB,0,1,0), e(OUT,0,0,0), H, H, H, H, H, H, H}, 8'hFF, 12, 17};
    vecs[7] = '{{e(LDI,0,0,7), e(JMP,0,0,5), e(OUT,0,0,0), H, H, e(ADD,0,0,0), e(OUT,0,0,0), H, H, H},
                8'h0E, 16, 21};
    vecs[8] = '{{e(LDI,1,0,8'h42), 16'hB000, e(14,0,1,8'h23), e(OUT,1,0,0), H, H, H, H, H, H},
                8'h42, 16, 21};

    reset_a();
    reset_b();
    check("a_rst_cpu_out",   32'(ifa.cpu_out), 0);
    check("a_rst_out_valid", 32'(ifa.out_valid), 0);
    check("a_rst_halted",    32'(ifa.halted), 0);
    check("a_rst_busy",      32'(ifa.busy), 0);
    check("b_rst_cpu_out",   32'(ifb.cpu_out), 0);
    check("b_rst_halted",    32'(ifb.halted), 0);

    // ---- directed program table ----
    for (int v = 0; v < 9; v++) begin
      reset_a();
      clear_buf();
      for (int i = 0; i < 10; i++) prog_buf[i] = vecs[v].prog[i];
      load_a();
      run_a(200, 1'b1);
      check($sformatf("v%0d_n_out", v), got_val.size(), 1);
      check_out($sformatf("v%0d_out", v), 0, vecs[v].exp_out, vecs[v].exp_cyc);
      check($sformatf("v%0d_halt_cyc", v), halt_cyc, vecs[v].exp_halt);
    end

    // ---- prog_we ignored while busy, honoured in HALT; run has no effect in HALT ----
    reset_a();
    clear_buf();
    prog_buf[0] = e(LDI,0,0,8'h11); prog_buf[1] = 16'hB000; prog_buf[2] = 16'hB000;
    prog_buf[3] = e(OUT,0,0,0);
    load_a();
    start_capture();
    @(negedge clk);
    ifa.run = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick_a(c);
      if (c == 2) begin ifa.prog_we = 1'b1; ifa.prog_addr = 6'd3; ifa.prog_data = H; end
      if (c == 3) ifa.prog_we = 1'b0;
    end
    check("busy_we_n_out", got_val.size(), 1);
    check_out("busy_we_out", 0, 8'h11, 16);
    check("busy_we_halt_cyc", halt_cyc, 21);
    @(negedge clk);
    ifa.prog_we = 1'b1; ifa.prog_addr = 6'd0; ifa.prog_data = e(LDI,0,0,8'h77);
    @(negedge clk);
    ifa.prog_we = 1'b0; ifa.run = 1'b0;
    for (int c = 31; c <= 34; c++) tick_a(c);
    ifa.run = 1'b1;
    for (int c = 35; c <= 50; c++) tick_a(c);
    ifa.run = 1'b0;
    check("halt_run_toggle_n_out", got_val.size(), 1);
    check("halt_run_toggle_halted", 32'(ifa.halted), 1);
    check("halt_run_toggle_busy", 32'(ifa.busy), 0);
    reset_a();
    check("halt_rst_frees", 32'(ifa.halted), 0);
    run_a(100, 1'b1);
    check("halt_we_n_out", got_val.size(), 1);
    check_out("halt_we_out", 0, 8'h77, 16);

    // ---- reset asserted in EXEC of ADD ----
    reset_a();
    clear_buf();
    prog_buf[0] = e(LDI,1,0,3); prog_buf[1] = e(OUT,1,0,0);
    prog_buf[2] = e(ADD,0,1,0); prog_buf[3] = e(OUT,0,0,0);
    load_a();
    start_capture();
    @(negedge clk);
    ifa.run = 1'b1;
    for (int c = 1; c <= 11; c++) tick_a(c);
    check_out("pre_rst_out", 0, 3, 8);
    check("pre_rst_busy", 32'(ifa.busy), 1);
    check("pre_rst_cpu_out", 32'(ifa.cpu_out), 3);
    ifa.run = 1'b0;
    rst_na = 1'b0;
    #1;
    check("mid_rst_cpu_out", 32'(ifa.cpu_out), 0);
    check("mid_rst_out_valid", 32'(ifa.out_valid), 0);
    check("mid_rst_halted", 32'(ifa.halted), 0);
    check("mid_rst_busy", 32'(ifa.busy), 0);
    @(negedge clk);
    rst_na = 1'b1;
    run_a(100, 1'b1);
    check("post_rst_n_out", got_val.size(), 2);
    check_out("post_rst_out0", 0, 3, 8);
    check_out("post_rst_out1", 1, 3, 16);
    check("post_rst_halt_cyc", halt_cyc, 21);

    // ---- run dropped mid-instruction, then resumed ----
    reset_a();
    clear_buf();
    prog_buf[0] = e(LDI,1,0,1); prog_buf[1] = e(ADD,0,1,0);
    prog_buf[2] = e(OUT,0,0,0); prog_buf[3] = e(JMP,0,0,1);
    load_a();
    start_capture();
    @(negedge clk);
    ifa.run = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick_a(c);
      if (c == 6) ifa.run = 1'b0;
      if (c == 8) check("drop_busy_in_wb", 32'(ifa.busy), 1);
      if (c == 9) check("drop_idle_after_wb", 32'(ifa.busy), 0);
    end
    check("drop_n_out", got_val.size(), 0);
    start_capture();
    @(negedge clk);
    ifa.run = 1'b1;
    for (int c = 1; c <= 16; c++) tick_a(c);
    ifa.run = 1'b0;
    check("resume_n_out", got_val.size(), 2);
    check_out("resume_out0", 0, 1, 4);
    check_out("resume_out1", 1, 2, 16);

    // ---- program write in the same cycle run rises ----
    reset_a();
    clear_buf();
    prog_buf[0] = e(LDI,0,0,8'h11); prog_buf[1] = e(OUT,0,0,0);
    load_a();
    start_capture();
    @(negedge clk);
    ifa.prog_we = 1'b1; ifa.prog_addr = 6'd0; ifa.prog_data = e(LDI,0,0,8'h5A); ifa.run = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick_a(c);
      if (c == 1) ifa.prog_we = 1'b0;
      if (halt_cyc >= 0) break;
    end
    ifa.run = 1'b0;
    check_out("we_run_out", 0, 8'h5A, 8);
    check("we_run_halt_cyc", halt_cyc, 13);

    // ---- random programs against the ISA model (dmem cleared first) ----
    reset_a();
    clear_buf();
    prog_buf[0] = e(LDI,0,0,0);
    for (int i = 0; i < 16; i++) prog_buf[1 + i] = e(ST,0,0,i);
    load_a();
    run_a(200, 1'b1);
    check("dmem_init_halt_cyc", halt_cyc, 4 * 18 + 1);
    for (int i = 0; i < 16; i++) mdmem[i] = 0;
    for (int t = 0; t < 20; t++) begin
      reset_a();
      for (int i = 0; i < 64; i++)
        prog_buf[i] = e($urandom_range(0, 14), $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 255));
      load_a();
      model_a(40);
      run_a(160, 1'b0);
      check($sformatf("rnd%0d_n_out", t), got_val.size(), exp_val.size());
      for (int i = 0; i < exp_val.size(); i++)
        check_out($sformatf("rnd%0d_out%0d", t, i), i, exp_val[i], exp_cyc[i]);
    end

    // ---- instance B: DW=4, PC_W=3, DA_W=2 ----
    reset_b();
    clear_buf();
    prog_buf[0] = e(BZ,0,0,6);    prog_buf[1] = e(LDI,0,0,8'hFF); prog_buf[2] = e(OUT,0,0,0);
    prog_buf[3] = e(LDI,1,0,1);   prog_buf[4] = e(ADD,0,1,0);     prog_buf[5] = e(BZ,0,0,8'h0F);
    prog_buf[6] = H;              prog_buf[7] = e(OUT,0,0,0);
    run_b(100);
    check("b_wrap_n_out", got_val.size(), 2);
    check_out("b_ldi_trunc", 0, 4'hF, 12);
    check_out("b_add_wrap_zero", 1, 0, 28);
    check("b_wrap_halt_cyc", halt_cyc, 37);

    reset_b();
    clear_buf();
    prog_buf[0] = e(LDI,0,0,1);     prog_buf[1] = e(JMP,0,0,8'h0B); prog_buf[2] = e(OUT,0,0,0);
    prog_buf[3] = e(LDI,0,0,8'h13); prog_buf[4] = e(OUT,0,0,0);
    run_b(100);
    check("b_jmp_n_out", got_val.size(), 1);
    check_out("b_jmp_trunc", 0, 3, 16);
    check("b_jmp_halt_cyc", halt_cyc, 21);

    reset_b();
    clear_buf();
    prog_buf[0] = e(LDI,2,0,5); prog_buf[1] = e(ST,2,0,3);
    prog_buf[2] = e(LD,3,0,7);  prog_buf[3] = e(OUT,3,0,0);
    run_b(100);
    check("b_daddr_n_out", got_val.size(), 1);
    check_out("b_daddr_trunc", 0, 5, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
